imem_loader: RTL and testbench

- Write-side companion to the read-only instruction memory of the LEGv8 pipeline.
- Accepts a byte stream from a host link (UART receiver or JTAG bridge) over a valid/ready handshake.
- Assembles little-endian 32-bit instructions and writes them to sequential word addresses of a writable instruction RAM.
- Holds the CPU stalled (`busy`) until the program is fully loaded.

---
 rtl/imem_pkg.sv | 7 +
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader.sv | 85 ++++++++
 tb/tb_imem_loader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared states and constants for the instruction-memory loader
package imem_pkg;
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH = 64;
  localparam logic [31:0] IMEM_NOP = 32'hd503201f;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream in, instruction RAM write port out
interface imem_loader_if import imem_pkg::*; #(parameter int ADDR_W = IMEM_ADDR_W);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;
  modport slave (input in_valid, in_data, output in_ready, we, waddr, wdata);
  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian host bytes into instruction RAM writes
module imem_loader import imem_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH = IMEM_DEPTH
) (
  input logic clk,
  input logic reset,
  input logic start,
  imem_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int CW = ADDR_W + 1;
  state_t state, nxt;
  logic [1:0] bcnt;
  logic [CW-1:0] wcnt, wnum, wnext, hdr_n;
  logic [23:0] sreg;
  logic accept, hdr_bad, parked;
  assign accept = bus.in_valid && bus.in_ready;
  assign hdr_bad = 32'(bus.in_data) > DEPTH;
  assign hdr_n = bus.in_data == 8'd0 ? CW'(DEPTH) : CW'(bus.in_data);
  assign wnext = wcnt + 1'b1;
  assign parked = state == IDLE || state == DONE || state == ERR;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? HDR : state;
      HDR: nxt = !accept ? HDR : hdr_bad ? ERR : DATA;
      DATA: nxt = accept && bcnt == 2'd3 ? WRITE : DATA;
      WRITE: nxt = wnext == wnum ? DONE : DATA;
      default: nxt = IDLE;
    endcase
  end
  // sreg collects bytes 0..2; the full word lands in wdata only on byte 3
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bcnt <= '0;
      wcnt <= '0;
      wnum <= '0;
      sreg <= '0;
      bus.in_ready <= 1'b0;
      bus.we <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nxt;
      bus.in_ready <= nxt == HDR || nxt == DATA;
      bus.we <= nxt == WRITE;
      if (parked && start) begin
        done <= 1'b0;
        error <= 1'b0;
        wcnt <= '0;
        bcnt <= '0;
        busy <= 1'b1;
      end
      if (state == HDR && accept) begin
        wnum <= hdr_n;
        if (hdr_bad) begin
          busy <= 1'b0;
          error <= 1'b1;
        end
      end
      if (state == DATA && accept) begin
        sreg <= {bus.in_data, sreg[23:8]};
        bcnt <= bcnt + 1'b1;
        if (bcnt == 2'd3) begin
          bus.wdata <= {bus.in_data, sreg};
          bus.waddr <= wcnt[ADDR_W-1:0];
        end
      end
      if (state == WRITE) begin
        wcnt <= wnext;
        if (wnext == wnum) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized load sessions checked against a byte-to-word reference model
module tb_imem_loader;
  import imem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;
  int checks = 0;
  int errors = 0;
  logic [7:0] payload [256];
  logic [37:0] got [$];
  imem_loader_if #(.ADDR_W(IMEM_ADDR_W)) bus ();
  imem_loader #(.ADDR_W(IMEM_ADDR_W), .DEPTH(IMEM_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      got.push_back({bus.waddr, bus.wdata});
      chk("ready_in_write", 64'(bus.in_ready), 64'd0);
    end
  end
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gmax);
    int t = 0;
    bus.in_valid = 1'b0;
    repeat ($urandom_range(gmax, 0)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'(t), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = 8'($urandom);
  endtask
  task automatic fill_random();
    for (int i = 0; i < 256; i++) payload[i] = 8'($urandom);
  endtask
  task automatic set_word(input int i, input logic [31:0] w);
    for (int k = 0; k < 4; k++) payload[4*i+k] = w[8*k +: 8];
  endtask
  task automatic run_load(input logic [7:0] hdr, input int gmax);
    int n, t;
    logic ok;
    logic [31:0] w;
    logic [5:0] a;
    got.delete();
    n = hdr == 8'd0 ? IMEM_DEPTH : int'(hdr);
    ok = n <= IMEM_DEPTH;
    pulse_start();
    chk("busy_start", 64'(busy), 64'd1);
    send_byte(hdr, gmax);
    if (ok)
      for (int j = 0; j < 4*n; j++) begin
        send_byte(payload[j], gmax);
        chk("we_latency", 64'(bus.we), 64'(j % 4 == 3));
      end
    t = 0;
    while (busy !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("busy_end", 64'(busy), 64'd0);
    chk("done", 64'(done), 64'(ok));
    chk("error", 64'(error), 64'(!ok));
    if (!ok) n = 0;
    chk("write_count", 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      w = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
      a = 6'(i);
      chk("write", 64'(got[i]), 64'({a, w}));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] hdr;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.we), 64'd0);
    chk("rst_waddr", 64'(bus.waddr), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_word(0, IMEM_NOP);
    run_load(8'd1, 0);
    if (got.size() > 0) chk("nop_word", 64'(got[0][31:0]), 64'hd503201f);
    set_word(0, 32'h8b1f03e0);
    set_word(1, 32'h91002001);
    set_word(2, 32'hf8000001);
    run_load(8'd3, 0);
    for (int i = 0; i < 256; i++) payload[i] = (i % 4 == 0) ? 8'(i / 4) : 8'h00;
    run_load(8'd0, 0);
    if (got.size() == 64) chk("last_write", 64'(got[63]), {26'd0, 6'd63, 32'd63});
    run_load(8'd65, 0);
    set_word(0, IMEM_NOP);
    run_load(8'd1, 0);
    fill_random();
    run_load(8'd4, 0);
    run_load(8'd4, 5);
    fill_random();
    got.delete();
    pulse_start();
    send_byte(8'd2, 0);
    for (int j = 0; j < 6; j++) send_byte(payload[j], 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_we", 64'(bus.we), 64'd0);
    chk("mid_rst_waddr", 64'(bus.waddr), 64'd0);
    chk("mid_rst_wdata", 64'(bus.wdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_error", 64'(error), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("pre_rst_writes", 64'(got.size()), 64'd1);
    got.delete();
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5a;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 64'(bus.in_ready), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    bus.in_valid = 1'b0;
    chk("idle_writes", 64'(got.size()), 64'd0);
    run_load(8'd2, 2);
    for (int r = 0; r < 5; r++) begin
      fill_random();
      hdr = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 65)) : 8'($urandom_range(8, 1));
      run_load(hdr, 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
